halmem_fifo_drainer: RTL
========================

Name: halmem_fifo_drainer

Overview:
Consumer end of the HALMEM write FIFO. It pops 24-bit entries {addr[15:0], data[7:0]} one at a time and replays each as a single write transaction on a req/ack memory-write port. It sits between the FIFO's pop side and the downstream memory/sound-chip write arbiter, with a programmable inter-write gap and an ack timeout.

Parameters:
GAP_CYCLES, 2, idle cycles inserted after each completed or abandoned write (0..255; 0 means no gap)
ACK_TIMEOUT, 1023, max cycles o_WR_REQ is held without i_WR_ACK before the write is abandoned (1..65535; 0 disables timeout)

Ports:
i_CLK  in  1  system clock
i_RST_n  in  1  reset; asynchronous, active-low
i_ENABLE  in  1  level; 1 allows new pops
i_EMPTY  in  1  FIFO empty flag (combinational from FIFO)
o_POP_S  out  1  one-cycle pop strobe to FIFO
i_POP_DT  in  24  FIFO read data; valid the cycle after o_POP_S
o_WR_REQ  out  1  write request, held until ack or timeout
o_WR_ADDR  out  16  write address = latched i_POP_DT[23:8]
o_WR_DATA  out  8  write data = latched i_POP_DT[7:0]
i_WR_ACK  in  1  write accepted (sampled only while o_WR_REQ=1)
o_TIMEOUT  out  1  one-cycle pulse when a write is abandoned
o_BUSY  out  1  1 whenever state != IDLE
o_DRAIN_CNT  out  16  completed-write counter (optional feature)
o_TMO_CNT  out  8  timeout counter (optional feature)
i_STAT_CLR  in  1  synchronous clear of the statistics counters

Behaviour:
- Reset (async, i_RST_n=0): state=IDLE; o_POP_S, o_WR_REQ, o_TIMEOUT=0; o_WR_ADDR, o_WR_DATA=0; gap/timeout counters=0; o_DRAIN_CNT, o_TMO_CNT=0. A word already popped when reset asserts is discarded.
- All outputs are registered.
- FSM states: IDLE, POP, LOAD, REQ, GAP.
- IDLE: if i_ENABLE=1 and i_EMPTY=0, assert o_POP_S for exactly one cycle -> POP. Otherwise stay in IDLE.
- POP: o_POP_S=0; the FIFO updates its data on this edge -> LOAD.
- LOAD: latch o_WR_ADDR<=i_POP_DT[23:8] and o_WR_DATA<=i_POP_DT[7:0]; set o_WR_REQ<=1; clear the timeout counter -> REQ.
- REQ: o_WR_ADDR and o_WR_DATA are held stable.
  - On the edge where i_WR_ACK=1: o_WR_REQ<=0 and the completed count increments; go to GAP if GAP_CYCLES>0, else IDLE.
  - Otherwise the timeout counter increments. If ACK_TIMEOUT!=0 and the counter reaches ACK_TIMEOUT-1 without ack: o_WR_REQ<=0 and o_TIMEOUT pulses for 1 cycle; go to GAP, or IDLE if GAP_CYCLES=0.
  - If ack arrives on the same cycle the timeout expires, the ack wins: the write counts as completed and there is no o_TIMEOUT pulse.
- GAP: count GAP_CYCLES cycles, then go to IDLE.
- Minimum period per word with ack in the first REQ cycle: 4 + GAP_CYCLES cycles (IDLE, POP, LOAD, REQ, then the gap).
- Pop rule: o_POP_S is asserted only from IDLE with i_EMPTY=0. The drainer never pops an empty FIFO and never has more than one word in flight.
- i_ENABLE=0 mid-transaction: the current word completes normally; only new pops are blocked.
- i_WR_ACK while o_WR_REQ=0 is ignored.
- Address and data widths are fixed; there is no arithmetic on the payload.
- FIFO index wrap-around is invisible to this block.

Optional Feature:
Macro HALMEM_DRAIN_STAT_EN.
- Defined:
  - o_DRAIN_CNT increments (wrapping at 16 bits) on each acked write.
  - o_TMO_CNT increments on each timeout and saturates at 8'hFF.
  - i_STAT_CLR=1 clears both counters on the next edge; a clear in the same cycle as an increment wins (result 0).
- Undefined: both counters are constant 0, i_STAT_CLR is ignored, and no counter registers are synthesized. Ports are present in both builds.

Test Plan:
- Reset, FIFO holding 24'h12_34_56, i_ENABLE=1, ack on the first REQ cycle:
  - one o_POP_S pulse, then o_WR_ADDR=16'h1234 and o_WR_DATA=8'h56 with o_WR_REQ=1 two cycles after the pop;
  - o_WR_REQ drops after ack; o_BUSY clears after 2 gap cycles.
- Three queued words (0x000001, 0x00FF02, 0xFFFF03), ack always high, GAP_CYCLES=0:
  - writes appear in FIFO order, exactly 4 cycles apart;
  - exactly 3 pops; no pop once i_EMPTY=1.
- ACK_TIMEOUT=8, ack never asserted:
  - o_WR_REQ is high for 8 cycles, then one o_TIMEOUT pulse;
  - the next queued word is still drained; o_TMO_CNT=1 when HALMEM_DRAIN_STAT_EN is defined.
- Ack on exactly the cycle the timeout expires -> no o_TIMEOUT pulse; o_DRAIN_CNT increments by 1.
- i_ENABLE dropped during REQ with 2 words queued -> the current write completes, and no further o_POP_S until i_ENABLE=1 again.
- i_RST_n pulsed low during REQ -> o_WR_REQ=0 immediately (asynchronously), state returns to IDLE, the in-flight word is lost, and draining resumes from the next FIFO entry.

Source files
------------

// File: rtl/halmem_fifo_drainer.sv
// HALMEM write-FIFO drainer: pops one word at a time and replays it as a req/ack write.
// Statistics counters (o_DRAIN_CNT, o_TMO_CNT) exist only when HALMEM_DRAIN_STAT_EN is defined.
module halmem_fifo_drainer #(
   parameter int unsigned GAP_CYCLES  = 2,
   parameter int unsigned ACK_TIMEOUT = 1023
) (
   input  logic        i_CLK,
   input  logic        i_RST_n,
   input  logic        i_ENABLE,
   input  logic        i_EMPTY,
   output logic        o_POP_S,
   input  logic [23:0] i_POP_DT,
   output logic        o_WR_REQ,
   output logic [15:0] o_WR_ADDR,
   output logic [7:0]  o_WR_DATA,
   input  logic        i_WR_ACK,
   output logic        o_TIMEOUT,
   output logic        o_BUSY,
   output logic [15:0] o_DRAIN_CNT,
   output logic [7:0]  o_TMO_CNT,
   input  logic        i_STAT_CLR,
   output logic [2:0]  o_STATE
);

   // Write handshake: o_WR_REQ rises with o_WR_ADDR/o_WR_DATA valid and holds them stable
   // until the edge where i_WR_ACK=1 (transfer) or the timeout abandons the write;
   // i_WR_ACK is ignored while o_WR_REQ=0.
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_POP  = 3'd1,
      S_LOAD = 3'd2,
      S_REQ  = 3'd3,
      S_GAP  = 3'd4
   } state_t;

   localparam bit         TMO_EN   = (ACK_TIMEOUT != 0);
   localparam logic [15:0] TMO_LAST = TMO_EN ? 16'(ACK_TIMEOUT - 1) : 16'd0;
   localparam logic [7:0]  GAP_LAST = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
   localparam state_t      AFTER_WR = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;

   state_t      state_q, state_d;
   logic        pop_q, pop_d;
   logic        req_q, req_d;
   logic        tmo_pulse_q, tmo_pulse_d;
   logic        busy_q, busy_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic        ack_evt;
   logic        tmo_evt;

   always_comb begin
      state_d     = state_q;
      pop_d       = 1'b0;
      req_d       = req_q;
      tmo_pulse_d = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      tmo_cnt_d   = tmo_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      ack_evt     = 1'b0;
      tmo_evt     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (i_ENABLE && !i_EMPTY) begin
               pop_d   = 1'b1;
               state_d = S_POP;
            end
         end
         S_POP: state_d = S_LOAD;
         S_LOAD: begin
            addr_d    = i_POP_DT[23:8];
            data_d    = i_POP_DT[7:0];
            req_d     = 1'b1;
            tmo_cnt_d = 16'd0;
            state_d   = S_REQ;
         end
         S_REQ: begin
            // An ack on the expiry cycle takes priority over the timeout.
            if (i_WR_ACK) begin
               req_d     = 1'b0;
               ack_evt   = 1'b1;
               gap_cnt_d = 8'd0;
               state_d   = AFTER_WR;
            end else if (TMO_EN && (tmo_cnt_q == TMO_LAST)) begin
               req_d       = 1'b0;
               tmo_pulse_d = 1'b1;
               tmo_evt     = 1'b1;
               gap_cnt_d   = 8'd0;
               state_d     = AFTER_WR;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
            end
         end
         S_GAP: begin
            if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
            else gap_cnt_d = gap_cnt_q + 8'd1;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         state_q     <= S_IDLE;
         pop_q       <= 1'b0;
         req_q       <= 1'b0;
         tmo_pulse_q <= 1'b0;
         busy_q      <= 1'b0;
         addr_q      <= 16'd0;
         data_q      <= 8'd0;
         tmo_cnt_q   <= 16'd0;
         gap_cnt_q   <= 8'd0;
      end else begin
         state_q     <= state_d;
         pop_q       <= pop_d;
         req_q       <= req_d;
         tmo_pulse_q <= tmo_pulse_d;
         busy_q      <= busy_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         tmo_cnt_q   <= tmo_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   assign o_POP_S   = pop_q;
   assign o_WR_REQ  = req_q;
   assign o_WR_ADDR = addr_q;
   assign o_WR_DATA = data_q;
   assign o_TIMEOUT = tmo_pulse_q;
   assign o_BUSY    = busy_q;
   assign o_STATE   = state_q;

`ifdef HALMEM_DRAIN_STAT_EN
   logic [15:0] drain_cnt_q;
   logic [7:0]  tmo_stat_q;

   // Clear beats a same-cycle increment; the timeout count saturates, the drain count wraps.
   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) begin
         drain_cnt_q <= 16'd0;
         tmo_stat_q  <= 8'd0;
      end else if (i_STAT_CLR) begin
         drain_cnt_q <= 16'd0;
         tmo_stat_q  <= 8'd0;
      end else begin
         if (ack_evt) drain_cnt_q <= drain_cnt_q + 16'd1;
         if (tmo_evt && (tmo_stat_q != 8'hFF)) tmo_stat_q <= tmo_stat_q + 8'd1;
      end
   end

   assign o_DRAIN_CNT = drain_cnt_q;
   assign o_TMO_CNT   = tmo_stat_q;
`else
   logic unused_stat;
   assign unused_stat = ^{i_STAT_CLR, ack_evt, tmo_evt};
   assign o_DRAIN_CNT = 16'd0;
   assign o_TMO_CNT   = 8'd0;
`endif

endmodule
